// File: rtl/seg_pkg.sv
// seg_pkg: shared pattern constants and FSM state type for seg_scan_encoder
// Exports SEG_0..SEG_3 (segment patterns, bit 6 = a .. bit 0 = g) and seg_state_t.
package seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    typedef enum logic {COLLECT, EVAL} seg_state_t;
endpackage

// File: rtl/seg_pattern_encoder.sv
// seg_pattern_encoder: maps a seven-segment pattern back to its 2-bit digit value
// Ports: seg (7-bit pattern in), value (2-bit digit out), valid (pattern is one of SEG_0..SEG_3).
module seg_pattern_encoder
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [1:0] value,
    output logic       valid
);
    always_comb begin
        value = seg == SEG_1 ? 2'd1 : seg == SEG_2 ? 2'd2 : seg == SEG_3 ? 2'd3 : 2'd0;
        valid = seg inside {SEG_0, SEG_1, SEG_2, SEG_3};
    end
endmodule

// File: rtl/seg_scan_encoder.sv
// seg_scan_encoder: rebuilds 2-bit digit frames from a multiplexed seven-segment bus
// Ports: clk, rst (async, active-high), strobe/seg/dig_en (scan samples),
// out_value/out_valid/out_ready (frame handshake), err (bad sample pulse),
// overrun (stable frame dropped while output occupied).
module seg_scan_encoder
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [2*DIGITS-1:0]   out_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic                  overrun
);
    localparam int CW = $clog2(STABLE_SCANS + 1);

    seg_state_t            state, state_nx;
    logic [2*DIGITS-1:0]   scan_buf, prev_frame;
    logic [DIGITS-1:0]     seen, seen_nx;
    logic [CW-1:0]         stable_cnt, cnt_nx;
    logic [1:0]            pat_value;
    logic                  pat_valid, good, bad, eval, same, deliver;

    seg_pattern_encoder u_enc (
        .seg   (seg),
        .value (pat_value),
        .valid (pat_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nx;
    end

    // A strobe during EVAL starts the next scan, so seen is cleared before the new bit is merged.
    always_comb begin
        eval     = state == EVAL;
        good     = strobe && $onehot(dig_en) && pat_valid;
        bad      = strobe && !good;
        seen_nx  = bad ? '0 : ((eval ? '0 : seen) | (good ? dig_en : '0));
        state_nx = &seen_nx ? EVAL : COLLECT;
    end

    // Delivery fires only on the transition into the saturated count; a count reset to 1
    // is itself the first step of a new run, which already qualifies when one scan suffices.
    always_comb begin
        same    = scan_buf == prev_frame;
        deliver = eval && (same ? stable_cnt == CW'(STABLE_SCANS - 1) : STABLE_SCANS == 1);
        cnt_nx  = bad ? '0 : !eval ? stable_cnt : !same ? CW'(1) :
                  stable_cnt == CW'(STABLE_SCANS) ? stable_cnt : stable_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen       <= '0;
            stable_cnt <= '0;
            scan_buf   <= '0;
            prev_frame <= '0;
            out_value  <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            seen       <= seen_nx;
            stable_cnt <= cnt_nx;
            err        <= bad;
            overrun    <= deliver && out_valid && !out_ready;
            if (eval) prev_frame <= scan_buf;
            for (int i = 0; i < DIGITS; i++)
                if (good && dig_en[i]) scan_buf[2*i +: 2] <= pat_value;
            if (deliver && (!out_valid || out_ready)) begin
                out_value <= scan_buf;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_encoder.sv
// tb_seg_scan_encoder: scoreboard bench for seg_scan_encoder (DIGITS=4, STABLE_SCANS=2)
module tb_seg_scan_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic [6:0] seg = '0;
    logic [3:0] dig_en = '0;
    logic [7:0] out_value;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int deliv_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    seg_scan_encoder #(.DIGITS(4), .STABLE_SCANS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe    (strobe),
        .seg       (seg),
        .dig_en    (dig_en),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input logic [1:0] v);
        case (v)
            2'd0:    pat = 7'b1111110;
            2'd1:    pat = 7'b0110000;
            2'd2:    pat = 7'b1101101;
            default: pat = 7'b1111001;
        endcase
    endfunction

    // Handshake consumer: every accepted frame is popped from the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt++;
            if (overrun) ovr_cnt++;
            if (out_valid && out_ready) begin
                deliv_cnt++;
                if (exp_q.size() == 0) check("spurious_frame", out_valid, 0);
                else check("frame", out_value, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_raw(input logic [3:0] en, input logic [6:0] s);
        strobe = 1'b1;
        dig_en = en;
        seg    = s;
        tick();
        strobe = 1'b0;
        dig_en = '0;
        seg    = '0;
    endtask

    task automatic scan(input logic [7:0] f);
        for (int d = 0; d < 4; d++) send_raw(4'(1 << d), pat(f[2*d +: 2]));
    endtask

    initial begin
        idle(2);
        check("rst_valid", out_valid, 0);
        check("rst_value", out_value, 0);
        check("rst_err", err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(1);

        // stable delivery with two-cycle latency, no re-delivery on third scan
        scan(8'he4);
        exp_q.push_back(8'he4);
        scan(8'he4);
        check("lat_eval_valid", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_value", out_value, 8'he4);
        scan(8'he4);
        idle(3);
        check("single_delivery", deliv_cnt, 1);

        // bad pattern mid-scan clears seen and the stable count
        scan(8'h1b);
        send_raw(4'b0001, pat(2'd3));
        send_raw(4'b0010, 7'b0000000);
        check("err_pattern", err, 1);
        tick();
        check("err_one_cycle", err, 0);
        scan(8'h1b);
        idle(3);
        check("no_early_delivery", deliv_cnt, 1);
        exp_q.push_back(8'h1b);
        scan(8'h1b);
        idle(3);
        check("delivery_after_err", deliv_cnt, 2);

        // bad digit selects
        send_raw(4'b0110, pat(2'd1));
        check("err_multi_hot", err, 1);
        tick();
        send_raw(4'b0000, pat(2'd2));
        check("err_zero_sel", err, 1);
        tick();
        check("err_count", err_cnt, 3);

        // backpressure: second stable frame is dropped with overrun
        out_ready = 1'b0;
        scan(8'hb1);
        exp_q.push_back(8'hb1);
        scan(8'hb1);
        idle(2);
        check("bp_valid", out_valid, 1);
        check("bp_value", out_value, 8'hb1);
        scan(8'h4e);
        scan(8'h4e);
        tick();
        check("overrun_pulse", overrun, 1);
        check("bp_hold_value", out_value, 8'hb1);
        out_ready = 1'b1;
        tick();
        check("bp_drained", out_valid, 0);
        check("overrun_count", ovr_cnt, 1);
        check("bp_deliv", deliv_cnt, 3);

        // handshake coinciding with a new delivery keeps out_valid high
        out_ready = 1'b0;
        scan(8'h39);
        exp_q.push_back(8'h39);
        scan(8'h39);
        idle(1);
        scan(8'hc6);
        exp_q.push_back(8'hc6);
        scan(8'hc6);
        out_ready = 1'b1;
        tick();
        check("no_gap_valid", out_valid, 1);
        check("no_gap_value", out_value, 8'hc6);
        tick();
        check("no_gap_done", out_valid, 0);
        check("no_gap_overrun", ovr_cnt, 1);
        check("no_gap_deliv", deliv_cnt, 5);

        // async reset mid-scan while a frame is held
        out_ready = 1'b0;
        scan(8'h93);
        exp_q.push_back(8'h93);
        scan(8'h93);
        idle(1);
        check("held_before_rst", out_valid, 1);
        send_raw(4'b0001, pat(2'd0));
        send_raw(4'b0010, pat(2'd1));
        #1 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_value", out_value, 0);
        check("arst_err", err, 0);
        check("arst_overrun", overrun, 0);
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        scan(8'he4);
        idle(3);
        check("post_rst_first_scan", deliv_cnt, 5);
        exp_q.push_back(8'he4);
        scan(8'he4);
        check("post_rst_eval_valid", out_valid, 0);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_value", out_value, 8'he4);
        idle(3);
        check("post_rst_deliv", deliv_cnt, 6);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
